// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the uDLX pipeline hazard controller.
// Holds the sequencing FSM state encoding and the hard-wired zero register
// index, so decode and debug logic can reuse them.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  // Register r0 is hard-wired to zero and never creates a hazard.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_sat_counter.sv
// Parameterised-width saturating up-counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : increment by one unless already at MAX_VAL
//   cnt_o      : current count
module hazard_sat_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != MAX_VAL)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the uDLX core.
// Detects load-use hazards, freezes the pipeline during multi-cycle loads,
// sequences branch flushes (including branches resolved during a memory
// wait), runs a memory-wait watchdog and counts PC stall cycles.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   id_*                   : source registers / read enables of the ID instruction
//   ex_*                   : load flag, write enable and destination of the EX instruction
//   mem_load_in/ready_in   : outstanding MEM-stage load and its data-return strobe
//   branch_taken_in        : branch resolved taken in EX
//   *_stall_out            : hold PC, IF/ID, ID/EX, EX/MEM
//   id_ex_bubble_out       : load NOP into ID/EX
//   if_id_flush_out        : clear IF/ID
//   mem_timeout_out        : sticky watchdog error
//   stall_cnt_out          : saturating count of PC stall cycles
// MEM_TIMEOUT must be at least 2.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_addr_a_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_addr_b_in,
  input  logic                      id_rd_a_ena_in,
  input  logic                      id_rd_b_ena_in,
  input  logic                      ex_load_in,
  input  logic                      ex_wr_ena_in,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dst_addr_in,
  input  logic                      mem_load_in,
  input  logic                      mem_ready_in,
  input  logic                      branch_taken_in,
  output logic                      pc_stall_out,
  output logic                      if_id_stall_out,
  output logic                      id_ex_stall_out,
  output logic                      ex_mem_stall_out,
  output logic                      id_ex_bubble_out,
  output logic                      if_id_flush_out,
  output logic                      mem_timeout_out,
  output logic [CNT_WIDTH-1:0]      stall_cnt_out
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  // The cycle whose increment brings wait_cnt to MEM_TIMEOUT fires the watchdog.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] R0 = REG_ADDR_WIDTH'(ZERO_REG);

  state_e            state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc, wait_clr;
  logic              stall_all, flush_c, lu_c;
  logic              mem_wait, load_use;

  assign mem_wait = mem_load_in & ~mem_ready_in;
  assign load_use = ex_load_in & ex_wr_ena_in & (ex_dst_addr_in != R0) &
                    ((id_rd_a_ena_in & (id_addr_a_in == ex_dst_addr_in)) |
                     (id_rd_b_ena_in & (id_addr_b_in == ex_dst_addr_in)));

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    timeout_d    = timeout_q;
    stall_all    = 1'b0;
    flush_c      = 1'b0;
    lu_c         = 1'b0;
    wait_inc     = 1'b0;
    wait_clr     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          stall_all = 1'b1;
          wait_inc  = 1'b1;
          state_d   = MEM_WAIT;
          if (branch_taken_in) flush_pend_d = 1'b1;
        end else if (branch_taken_in || flush_pend_q) begin
          // Flush wins over load-use: the ID instruction is wrong-path.
          flush_c      = 1'b1;
          flush_pend_d = 1'b0;
        end else if (load_use) begin
          lu_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (branch_taken_in) flush_pend_d = 1'b1;
        if (mem_ready_in) begin
          wait_clr = 1'b1;
          state_d  = RUN;
        end else begin
          stall_all = 1'b1;
          wait_inc  = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = TIMEOUT;
          end
        end
      end
      TIMEOUT: stall_all = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      timeout_q    <= timeout_d;
    end
  end

  hazard_sat_counter #(.WIDTH(WAIT_W), .MAX_VAL(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (wait_clr),
    .inc_i (wait_inc),
    .cnt_o (wait_cnt)
  );

  hazard_sat_counter #(.WIDTH(CNT_WIDTH), .MAX_VAL('1)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (pc_stall_out),
    .cnt_o (stall_cnt_out)
  );

  // Controls are decoded combinationally from inputs, so gate them with
  // reset to keep them low while rst_n is asserted.
  assign pc_stall_out     = rst_n & (stall_all | lu_c);
  assign if_id_stall_out  = rst_n & (stall_all | lu_c);
  assign id_ex_stall_out  = rst_n & stall_all;
  assign ex_mem_stall_out = rst_n & stall_all;
  assign id_ex_bubble_out = rst_n & (flush_c | lu_c);
  assign if_id_flush_out  = rst_n & flush_c;
  assign mem_timeout_out  = timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (MEM_TIMEOUT=8, CNT_WIDTH=4).
// Control vector order: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
// id_ex_bubble, if_id_flush}.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_addr_a, id_addr_b, ex_dst;
  logic       rd_a, rd_b, ex_load, ex_wr, mem_load, mem_ready, br;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, bubble, flush;
  logic       timeout;
  logic [3:0] stall_cnt;
  logic [5:0] ctl;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_addr_a_in     (id_addr_a),
    .id_addr_b_in     (id_addr_b),
    .id_rd_a_ena_in   (rd_a),
    .id_rd_b_ena_in   (rd_b),
    .ex_load_in       (ex_load),
    .ex_wr_ena_in     (ex_wr),
    .ex_dst_addr_in   (ex_dst),
    .mem_load_in      (mem_load),
    .mem_ready_in     (mem_ready),
    .branch_taken_in  (br),
    .pc_stall_out     (pc_stall),
    .if_id_stall_out  (if_id_stall),
    .id_ex_stall_out  (id_ex_stall),
    .ex_mem_stall_out (ex_mem_stall),
    .id_ex_bubble_out (bubble),
    .if_id_flush_out  (flush),
    .mem_timeout_out  (timeout),
    .stall_cnt_out    (stall_cnt)
  );

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, bubble, flush};

  typedef struct {
    string      name;
    logic [4:0] a, b;
    logic       ra, rb, exl, exw;
    logic [4:0] dst;
    logic       ml, mr, br;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [4:0] a, logic [4:0] b, logic ra, logic rb,
                              logic exl, logic exw, logic [4:0] dst, logic ml, logic mr,
                              logic brv, logic [5:0] exp);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.ra = ra; v.rb = rb; v.exl = exl; v.exw = exw;
    v.dst = dst; v.ml = ml; v.mr = mr; v.br = brv; v.exp = exp;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(vec_t v);
    id_addr_a = v.a; id_addr_b = v.b; rd_a = v.ra; rd_b = v.rb;
    ex_load = v.exl; ex_wr = v.exw; ex_dst = v.dst;
    mem_load = v.ml; mem_ready = v.mr; br = v.br;
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    set_in(v);
    #1;
    chk(v.name, 32'(ctl), 32'(v.exp));
  endtask

  // Memory/branch-only cycle with the decode inputs idle.
  task automatic step(string nm, logic ml, logic mr, logic brv, logic [5:0] exp);
    apply(mk(nm, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, ml, mr, brv, exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with a load-use hazard on the inputs: every control must stay low.
    rst_n = 1'b0;
    set_in(mk("rst", 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 6'd0));
    #2;
    chk("reset_ctl", 32'(ctl), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    do_reset();

    // Single-cycle RUN-state decode vectors.
    vecs.push_back(mk("idle",        5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("lu_a_r3",     5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 0, 0, 0, 6'b110010));
    vecs.push_back(mk("lu_b_r7",     5'd0, 5'd7, 0, 1, 1, 1, 5'd7, 0, 0, 0, 6'b110010));
    vecs.push_back(mk("r0_masked",   5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("rd_b_off",    5'd1, 5'd5, 1, 0, 1, 1, 5'd5, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("not_load",    5'd3, 5'd0, 1, 0, 0, 1, 5'd3, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("load_no_wr",  5'd3, 5'd0, 1, 0, 1, 0, 5'd3, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("addr_differ", 5'd4, 5'd2, 1, 1, 1, 1, 5'd3, 0, 0, 0, 6'b000000));
    vecs.push_back(mk("branch",      5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 1, 6'b000011));
    vecs.push_back(mk("branch_lu",   5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 0, 0, 1, 6'b000011));
    vecs.push_back(mk("load_ready",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 6'b000000));
    vecs.push_back(mk("ready_only",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 6'b000000));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    step("after_table", 1'b0, 1'b0, 1'b0, 6'd0);
    chk("table_stall_cnt", 32'(stall_cnt), 32'd2);

    // Load-use: one stall cycle, then clear; counter reads 1.
    do_reset();
    apply(mk("lu_seq", 5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 0, 0, 0, 6'b110010));
    step("lu_seq_after", 1'b0, 1'b0, 1'b0, 6'd0);
    chk("lu_seq_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait: three waiting cycles, ready on the fourth.
    do_reset();
    step("mw_1", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("mw_2", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("mw_3", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("mw_ready", 1'b1, 1'b1, 1'b0, 6'b000000);
    step("mw_idle", 1'b0, 1'b0, 1'b0, 6'b000000);
    chk("mw_cnt", 32'(stall_cnt), 32'd3);
    step("mw_run_branch", 1'b0, 1'b0, 1'b1, 6'b000011);

    // Branch in the second wait cycle is held until after ready.
    do_reset();
    step("bw_1", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("bw_2_branch", 1'b1, 1'b0, 1'b1, 6'b111100);
    step("bw_3", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("bw_ready", 1'b1, 1'b1, 1'b0, 6'b000000);
    step("bw_flush", 1'b0, 1'b0, 1'b0, 6'b000011);
    step("bw_after", 1'b0, 1'b0, 1'b0, 6'b000000);

    // Watchdog: eight wait cycles with no ready.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step("wd_wait", 1'b1, 1'b0, 1'b0, 6'b111100);
      chk("wd_no_timeout_yet", 32'(timeout), 32'd0);
    end
    step("wd_timeout_stalls", 1'b1, 1'b0, 1'b0, 6'b111100);
    chk("wd_timeout", 32'(timeout), 32'd1);
    step("wd_ready_ignored", 1'b1, 1'b1, 1'b0, 6'b111100);
    chk("wd_timeout_sticky", 32'(timeout), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("wd_async_timeout", 32'(timeout), 32'd0);
    chk("wd_async_ctl", 32'(ctl), 32'd0);
    chk("wd_async_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("wd_back_in_run", 1'b0, 1'b0, 1'b1, 6'b000011);

    // Saturation: twenty stall cycles on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) step("sat_stall", 1'b1, 1'b0, 1'b0, 6'b111100);
    @(negedge clk);
    #1;
    chk("sat_cnt", 32'(stall_cnt), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the uDLX core; sits beside the EX-stage forwarding logic and drives the stall, bubble and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards that forwarding cannot cover, freezes the pipeline while a multi-cycle data-memory load is outstanding, and sequences branch flushes, including a branch resolved during a memory wait.
- Also provides a memory-wait watchdog and a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before the watchdog fires.
- CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset.
- id_addr_a_in  in  REG_ADDR_WIDTH  source A register of the instruction in ID.
- id_addr_b_in  in  REG_ADDR_WIDTH  source B register of the instruction in ID.
- id_rd_a_ena_in  in  1  ID instruction reads source A.
- id_rd_b_ena_in  in  1  ID instruction reads source B.
- ex_load_in  in  1  EX instruction is a load.
- ex_wr_ena_in  in  1  EX instruction writes a register.
- ex_dst_addr_in  in  REG_ADDR_WIDTH  EX destination register.
- mem_load_in  in  1  MEM instruction is a load awaiting data.
- mem_ready_in  in  1  data memory returns load data this cycle.
- branch_taken_in  in  1  branch resolved taken in EX.
- pc_stall_out  out  1  hold PC.
- if_id_stall_out  out  1  hold IF/ID.
- id_ex_stall_out  out  1  hold ID/EX.
- ex_mem_stall_out  out  1  hold EX/MEM.
- id_ex_bubble_out  out  1  load NOP into ID/EX.
- if_id_flush_out  out  1  clear IF/ID.
- mem_timeout_out  out  1  sticky watchdog error.
- stall_cnt_out  out  CNT_WIDTH  total stall cycles.

Behaviour:
Reset and clocking:
- One clock (clk). Reset rst_n is asynchronous, active-low.
- During reset: state=RUN, flush_pend=0, wait_cnt=0, stall_cnt_out=0, mem_timeout_out=0.
- Every control output is low during reset and whenever no condition below applies.
- Reset asserted mid-operation aborts any wait or pending flush immediately.

Hazard terms:
- mem_wait = mem_load_in & ~mem_ready_in.
- load_use = ex_load_in & ex_wr_ena_in & (ex_dst_addr_in != 0) & ((id_rd_a_ena_in & id_addr_a_in == ex_dst_addr_in) | (id_rd_b_ena_in & id_addr_b_in == ex_dst_addr_in)).
- Register 0 never creates a hazard.

State RUN (outputs combinational from state and inputs, same cycle):
1. mem_wait:
   - All four stall outputs = 1; no bubble, no flush.
   - If branch_taken_in is also high, set flush_pend.
   - Next state MEM_WAIT; wait_cnt = 1.
2. Otherwise, branch_taken_in | flush_pend:
   - if_id_flush_out = 1 and id_ex_bubble_out = 1 for exactly one cycle; clear flush_pend.
   - A load_use in the same cycle is ignored, because the flushed instruction is wrong-path.
3. Otherwise, load_use:
   - pc_stall_out = 1, if_id_stall_out = 1, id_ex_bubble_out = 1 for one cycle.
   - Next cycle the load sits in MEM and the normal forwarding path resolves it.
   - A back-to-back load_use stalls again.

State MEM_WAIT:
- All four stall outputs = 1 every cycle.
- wait_cnt increments and saturates at MEM_TIMEOUT.
- branch_taken_in sets flush_pend; it is not lost.
- When mem_ready_in is high: stalls deassert that cycle, next state RUN, wait_cnt = 0. A set flush_pend is serviced in the following RUN cycle.
- When wait_cnt reaches MEM_TIMEOUT with no ready: set mem_timeout_out, next state TIMEOUT.

State TIMEOUT:
- All stalls held high; mem_timeout_out = 1.
- Left only by reset.

Stall-cycle counter:
- stall_cnt_out increments on every cycle with pc_stall_out = 1.
- Saturates at all-ones; no wrap.

Decomposition:
- Shared package holds the FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2) and the zero-register constant, for reuse by the decode and debug logic.
- One natural sub-module: hazard_sat_counter, a parameterised-width saturating counter used for both wait_cnt and stall_cnt_out.

Test Plan:
- Load-use: EX load to r3, ID reads r3 on port A -> one cycle with pc_stall=if_id_stall=bubble=1, then all low; stall_cnt_out = 1.
- R0 and disabled-read masking: EX load to r0 with ID reading r0, then EX load to r5 with ID holding addr_b=5 but id_rd_b_ena_in=0 -> no stall in either case.
- Memory wait: mem_load_in=1 with mem_ready_in low for 3 cycles, high on the 4th -> four stalls high for 3 cycles, low on the 4th; state returns to RUN.
- Branch during wait: branch_taken_in pulsed in the 2nd MEM_WAIT cycle -> no flush during the wait; if_id_flush and bubble high for exactly one cycle after ready.
- Watchdog: MEM_TIMEOUT=8, mem_ready_in never asserted -> mem_timeout_out rises after 8 wait cycles and stays high with stalls held; rst_n low clears everything asynchronously.
- Saturation: CNT_WIDTH=4 with 20 stall cycles -> stall_cnt_out = 15.
